// File: rtl/fp_arbiter.sv
// ---------------------------------------------------------------------------
// fp_arbiter
//
// Shares one multi-cycle floating-point unit between NUM_REQ requesters.
// Each requester fires a one-cycle start pulse together with its operands and
// opcode. The operands are latched locally and the request stays pending until
// it has been served. A round-robin FSM picks the next pending requester,
// issues the operation to the FP unit, waits for completion (bounded by
// TIMEOUT cycles) and returns a one-cycle done pulse to the granted requester.
//
// Parameters
//   NUM_REQ  number of requesters
//   TIMEOUT  maximum number of cycles spent in WAIT before the op is aborted
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   req_clk_en     per-requester start pulse
//   req_dataa/b    per-requester operands, requester i at [32i+31:32i]
//   req_operation  per-requester opcode, requester i at [3i+2:3i]
//   req_done       one-cycle completion pulse to the granted requester
//   req_result     result, valid while req_done is nonzero
//   req_error      high with req_done when the operation timed out
//   fp_dataa/b     operands to the FP unit
//   fp_operation   opcode to the FP unit
//   fp_clk_en      one-cycle start pulse to the FP unit
//   fp_done        FP unit completion
//   fp_result      FP unit result
//   busy           high whenever the FSM is not idle
//   grant_id       index of the current or most recent grant
// ---------------------------------------------------------------------------
module fp_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_clk_en,
    input  logic [32*NUM_REQ-1:0]  req_dataa,
    input  logic [32*NUM_REQ-1:0]  req_datab,
    input  logic [3*NUM_REQ-1:0]   req_operation,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [31:0]            req_result,
    output logic                   req_error,
    output logic [31:0]            fp_dataa,
    output logic [31:0]            fp_datab,
    output logic [2:0]             fp_operation,
    output logic                   fp_clk_en,
    input  logic                   fp_done,
    input  logic [31:0]            fp_result,
    output logic                   busy,
    output logic [GW-1:0]          grant_id
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    localparam int               CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]    CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [GW-1:0]    LAST_INIT  = GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);

    logic [1:0]          state_r;
    logic [NUM_REQ-1:0]  pending_r;
    logic [GW-1:0]       last_grant_r;
    logic [GW-1:0]       grant_id_r;
    logic [CW-1:0]       cnt_r;
    logic [31:0]         lat_dataa_r [NUM_REQ];
    logic [31:0]         lat_datab_r [NUM_REQ];
    logic [2:0]          lat_op_r    [NUM_REQ];

    logic [NUM_REQ-1:0]  req_done_r;
    logic [31:0]         req_result_r;
    logic                req_error_r;
    logic [31:0]         fp_dataa_r;
    logic [31:0]         fp_datab_r;
    logic [2:0]          fp_operation_r;
    logic                fp_clk_en_r;
    logic                busy_r;

    logic [NUM_REQ-1:0]  capture_s;
    logic                grant_found_s;
    logic [GW-1:0]       grant_next_s;

    // Capture qualification: a pulse is taken when the slot is free, or when the
    // slot is being released this very cycle (a new request beats the clear).
    always_comb begin
        capture_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_clk_en[i] && (!pending_r[i] ||
                                  ((state_r == S_RESPOND) && (grant_id_r == GW'(i))))) begin
                capture_s[i] = 1'b1;
            end else begin
                capture_s[i] = 1'b0;
            end
        end
    end

    // Round-robin search: first pending index after last_grant, wrapping around.
    always_comb begin
        grant_found_s = 1'b0;
        grant_next_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int            idx;
            logic [GW-1:0] idx_v;
            idx   = (int'(last_grant_r) + k) % NUM_REQ;
            idx_v = idx[GW-1:0];
            if (!grant_found_s && pending_r[idx_v]) begin
                grant_found_s = 1'b1;
                grant_next_s  = idx_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Pending flags and per-requester operand latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                lat_dataa_r[i] <= 32'h0000_0000;
                lat_datab_r[i] <= 32'h0000_0000;
                lat_op_r[i]    <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture_s[i]) begin
                    pending_r[i]   <= 1'b1;
                    lat_dataa_r[i] <= req_dataa[32*i +: 32];
                    lat_datab_r[i] <= req_datab[32*i +: 32];
                    lat_op_r[i]    <= req_operation[3*i +: 3];
                end else if ((state_r == S_RESPOND) && (grant_id_r == GW'(i))) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Arbitration FSM together with all registered outputs. fp_clk_en and
    // req_done are set on the transition into ISSUE/RESPOND so that they are
    // high exactly during those one-cycle states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= S_IDLE;
            last_grant_r   <= LAST_INIT;
            grant_id_r     <= '0;
            cnt_r          <= '0;
            req_done_r     <= '0;
            req_result_r   <= 32'h0000_0000;
            req_error_r    <= 1'b0;
            fp_dataa_r     <= 32'h0000_0000;
            fp_datab_r     <= 32'h0000_0000;
            fp_operation_r <= 3'd0;
            fp_clk_en_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            fp_clk_en_r <= 1'b0;
            req_done_r  <= '0;
            req_error_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (grant_found_s) begin
                        grant_id_r     <= grant_next_s;
                        fp_dataa_r     <= lat_dataa_r[grant_next_s];
                        fp_datab_r     <= lat_datab_r[grant_next_s];
                        fp_operation_r <= lat_op_r[grant_next_s];
                        fp_clk_en_r    <= 1'b1;
                        busy_r         <= 1'b1;
                        state_r        <= S_ISSUE;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion is checked first so that it wins over a
                    // simultaneous expiry of the timeout.
                    if (fp_done) begin
                        req_result_r <= fp_result;
                        req_error_r  <= 1'b0;
                        req_done_r   <= REQ_ONE << grant_id_r;
                        state_r      <= S_RESPOND;
                    end else if (cnt_r == CNT_LAST) begin
                        req_result_r <= 32'h0000_0000;
                        req_error_r  <= 1'b1;
                        req_done_r   <= REQ_ONE << grant_id_r;
                        state_r      <= S_RESPOND;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= S_WAIT;
                    end
                end
                S_RESPOND: begin
                    last_grant_r <= grant_id_r;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign req_done     = req_done_r;
    assign req_result   = req_result_r;
    assign req_error    = req_error_r;
    assign fp_dataa     = fp_dataa_r;
    assign fp_datab     = fp_datab_r;
    assign fp_operation = fp_operation_r;
    assign fp_clk_en    = fp_clk_en_r;
    assign busy         = busy_r;
    assign grant_id     = grant_id_r;

endmodule
